// File: rtl/regex_stream_controller.sv
// rtl/regex_stream_controller.sv - byte-stream front end for a replicated-word regex engine
//
// Purpose: packs incoming message bytes into R-byte engine words, strobes them
// into the engine, collects the engine's delayed match output per message and
// reports one result (match flag + byte count) per message.
//
// Ports:
//   clock, reset           single clock, asynchronous active-low reset
//   in_valid/in_ready      byte stream handshake; in_data byte, in_last ends message
//   rx_enable/rx_data      engine word strobe and packed word (lane k = bits [8k+7:8k])
//   rx_restart             one-cycle engine state clear between messages
//   rx_match               engine match, valid ENGINE_LATENCY cycles after rx_enable
//   res_valid/res_ready    result handshake; res_match, res_count result payload
module regex_stream_controller #(
  parameter int unsigned REPLICATION_FACTOR = 3,
  parameter int unsigned ENGINE_LATENCY     = 2,
  parameter logic [7:0]  PAD_BYTE           = 8'h00
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [7:0]                      in_data,
  input  logic                            in_last,
  output logic                            rx_enable,
  output logic [8*REPLICATION_FACTOR-1:0] rx_data,
  output logic                            rx_restart,
  input  logic                            rx_match,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            res_match,
  output logic [15:0]                     res_count
);

  localparam int unsigned R  = REPLICATION_FACTOR;
  localparam int unsigned L  = ENGINE_LATENCY;
  localparam int unsigned KW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned PW = (L > 0) ? L : 1;

  typedef enum logic [2:0] {
    S_FILL,
    S_ISSUE,
    S_DRAIN,
    S_REPORT,
    S_RESTART
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [8*R-1:0]  word_q, word_d;
  logic [8*R-1:0]  rx_data_q, rx_data_d;
  logic            last_q, last_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            sticky_q, sticky_d;
  logic            rdy_q;
  logic [PW-1:0]   pipe_q, pipe_d;

  logic [8*R-1:0]  pack;
  logic [L:0]      vld;
  logic            accept;
  logic            sample;
  logic            pending;

  assign in_ready  = rdy_q;
  assign rx_data   = rx_data_q;
  assign res_match = sticky_q;
  assign res_count = cnt_q;
  assign accept    = in_valid && rdy_q;

  // Word as it looks once the current byte lands in lane k. On the final byte
  // of a message every lane above it is forced to the pad value so the engine
  // never sees leftovers from an earlier word.
  always_comb begin
    pack = word_q;
    for (int j = 0; j < int'(R); j++) begin
      if (KW'(j) == k_q) begin
        pack[8*j +: 8] = in_data;
      end else if ((KW'(j) > k_q) && in_last) begin
        pack[8*j +: 8] = PAD_BYTE;
      end
    end
  end

  // vld[i] is 1 when a word issued i cycles ago is in flight; vld[L] marks the
  // cycle whose rx_match belongs to that word (the issue cycle itself if L = 0).
  always_comb begin
    vld    = '0;
    vld[0] = rx_enable;
    for (int i = 1; i <= int'(L); i++) begin
      vld[i] = pipe_q[i-1];
    end
  end

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = rx_enable;
    for (int i = 1; i < int'(PW); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign sample = vld[L];

  // Words still in flight that have not yet reached their sample cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < int'(L); i++) begin
      pending = pending | vld[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    word_d     = word_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q | (sample & rx_match);
    rx_enable  = 1'b0;
    rx_restart = 1'b0;
    res_valid  = 1'b0;

    case (state_q)
      S_FILL: begin
        if (accept) begin
          word_d = pack;
          cnt_d  = (cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
          if ((k_q == KW'(R - 1)) || in_last) begin
            rx_data_d = pack;
            last_d    = in_last;
            k_d       = '0;
            state_d   = S_ISSUE;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      S_ISSUE: begin
        rx_enable = 1'b1;
        if (last_q) begin
          // With no engine latency the sample happens here, so skip DRAIN to
          // keep the result at a fixed offset from the last byte.
          state_d = (L == 0) ? S_REPORT : S_DRAIN;
        end else begin
          state_d = S_FILL;
        end
      end
      S_DRAIN: begin
        if (!pending) begin
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = S_RESTART;
        end
      end
      S_RESTART: begin
        rx_restart = 1'b1;
        sticky_d   = 1'b0;
        cnt_d      = '0;
        k_d        = '0;
        last_d     = 1'b0;
        state_d    = S_FILL;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FILL;
      k_q       <= '0;
      word_q    <= '0;
      rx_data_q <= '0;
      last_q    <= 1'b0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      rdy_q     <= 1'b0;
      pipe_q    <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      word_q    <= word_d;
      rx_data_q <= rx_data_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      // Registered ready keeps in_ready low throughout reset and raises it on
      // the first edge after release.
      rdy_q     <= (state_d == S_FILL);
      pipe_q    <= pipe_d;
    end
  end

endmodule
